mode_controller: RTL and testbench
==================================

# mode_controller

Central sequencer for the clock/timer/stopwatch datapath. It takes debounced button levels, keeps the display mode (12 h, 24 h, timer, stopwatch) and drives the mux select. It routes toggle/add events only to the owning sub-block and generates run enables, stopwatch long-press clear and the timer-expiry alarm. It sits between the debouncers and the clock_12hr/clock_24hr/timer_top/stopwatch instances, and replaces the select counter.

## Interface
- ALARM_TICKS, 3000: alarm duration in khz_tick pulses (3 s at 1 kHz).
- CLR_TICKS, 1000: toggle hold time in stopwatch mode, in khz_tick pulses, that triggers a clear.
- clk  in  1  system clock; every flop is on its rising edge.
- reset  in  1  synchronous, active-high.
- khz_tick  in  1  one-clk pulse at 1 kHz, synchronous to clk.
- btn_select, btn_toggle, btn_add_one, btn_add_ten  in  1 each  debounced levels, synchronous to clk.
- ms_sw, sec_sw, min_sw, hr_sw  in  1 each  timer field-select switches.
- timer_zero  in  1  high while the timer count equals 0.
- select  out  2  mode: 0 = 12 h, 1 = 24 h, 2 = timer, 3 = stopwatch.
- tmr_run  out  1  timer count-down enable.
- sw_run  out  1  stopwatch count enable.
- sw_clear  out  1  one-clk pulse that clears the stopwatch.
- tmr_add_one, tmr_add_ten  out  1 each  one-clk increment pulses to the timer.
- tmr_field  out  2  0 = ms, 1 = sec, 2 = min, 3 = hr. Priority hr > min > sec > ms.
- field_valid  out  1  high when any field switch is on.
- alarm  out  1  timer-expired indication.

## Operation
- **Edge detection**
  - Each button has a previous-level register.
  - A press event is `btn & ~prev`.
  - A release event (toggle only) is `~btn & prev`.
- **Mode**
  - A select press advances `select` by 1, wrapping 3 → 0.
  - Run state persists across mode changes: the timer and stopwatch keep running in the background.
- **Alarm acknowledge**
  - While `alarm = 1`, any button press only clears `alarm`.
  - That press is consumed: no mode change, no toggle, no add.
- **Timer expiry**
  - Condition: `tmr_run = 1` and `timer_zero = 1` sampled.
  - Result: `tmr_run` clears to 0, `alarm` sets to 1, and the alarm counter loads ALARM_TICKS.
  - Each khz_tick decrements the alarm counter. `alarm` clears when the counter goes 1 → 0.
- **Toggle in timer mode**
  - A press flips `tmr_run`.
  - The press is ignored when `tmr_run = 0` and `timer_zero = 1`, so a zero timer cannot start.
- **Toggle in stopwatch mode**
  - The press starts the hold counter at 0. The hold counter increments on each khz_tick while toggle stays high.
  - When the hold count reaches CLR_TICKS: one `sw_clear` pulse, `sw_run` forced to 0, and the press is marked consumed.
  - Release with the press not consumed flips `sw_run`.
  - Release with the press consumed does nothing.
  - The hold counter saturates and is cleared on release.
- **Toggle in clock modes**
  - Ignored.
  - A mode change while toggle is held abandons the hold: the release is ignored and no clear occurs.
- **Add buttons**
  - Conditions: active only when `select = 2`, `tmr_run = 0`, `alarm = 0` and `field_valid = 1`.
  - An add_one press pulses `tmr_add_one`; an add_ten press pulses `tmr_add_ten`.
  - If both presses occur on the same clk, only `tmr_add_ten` fires.
  - Otherwise the presses are dropped.
- **Field select**
  - `tmr_field` and `field_valid` are combinational from the switches.
- **Same-clk priority**, highest first:
  1. reset
  2. alarm acknowledge
  3. timer expiry (a timer-mode toggle press on that clk is consumed)
  4. select
  5. toggle / add
- A select press and an add press on the same clk: the mode advances and the add is dropped.

## Timing
- **Reset values** (all outputs and state):
  - select = 0, tmr_run = 0, sw_run = 0, sw_clear = 0, tmr_add_one = 0, tmr_add_ten = 0, alarm = 0.
  - Hold and alarm counters = 0, edge registers = 0.
  - Consequence: a button held through reset gives no press on reset release.
- **Latency:** a button level first sampled high at edge n updates the registered outputs at edge n; they are visible in cycle n+1.
- **Pulses:** `sw_clear`, `tmr_add_one` and `tmr_add_ten` are exactly one clk wide, with at most one per button press.
- **Expiry:** `timer_zero` and `tmr_run` high at edge n give `tmr_run = 0` and `alarm = 1` after edge n.
- **Alarm duration:** `alarm` stays high for exactly ALARM_TICKS khz_ticks after expiry, unless acknowledged first.
- **Reset mid-hold or mid-alarm:** reset aborts immediately; no pending pulse is emitted.

## Test plan
- **Select wrap:** after reset, 5 select presses → select = 1, 2, 3, 0, 1.
- **Timer add gating**
  - Stimulus: select = 2, hr_sw = 1 and sec_sw = 1, add_one press.
  - Required: tmr_field = 3 and one tmr_add_one pulse.
  - Then with tmr_run = 1: add_ten press → no pulse.
  - With all switches off: add press → no pulse.
- **Expiry/alarm**
  - Stimulus: ALARM_TICKS = 5, tmr_run = 1, assert timer_zero.
  - Required: tmr_run = 0 and alarm = 1 for 5 ticks.
  - Repeat, then a select press during the alarm → alarm = 0 and select unchanged.
- **Stopwatch short/long press**
  - CLR_TICKS = 4.
  - Hold toggle for 2 ticks → sw_run flips on release.
  - Hold for 6 ticks → one sw_clear pulse at the 4th tick, sw_run = 0, and no flip on release.
- **Same-clk conflicts**
  - add_one and add_ten pressed together → only tmr_add_ten.
  - Toggle press on the expiry clk → tmr_run = 0 and alarm = 1.
- **Reset mid-operation:** reset asserted during a hold and during the alarm → all outputs at reset values next cycle, no sw_clear pulse.

Source files
------------

// File: rtl/mode_controller.sv
// Central sequencer for the clock/timer/stopwatch datapath: display mode, run enables,
// timer add routing, stopwatch long-press clear and the timer-expiry alarm.
module mode_controller #(
    parameter int ALARM_TICKS = 3000,
    parameter int CLR_TICKS   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       khz_tick,
    input  logic       btn_select,
    input  logic       btn_toggle,
    input  logic       btn_add_one,
    input  logic       btn_add_ten,
    input  logic       ms_sw,
    input  logic       sec_sw,
    input  logic       min_sw,
    input  logic       hr_sw,
    input  logic       timer_zero,
    output logic [1:0] select,
    output logic       tmr_run,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       tmr_add_one,
    output logic       tmr_add_ten,
    output logic [1:0] tmr_field,
    output logic       field_valid,
    output logic       alarm
);

    localparam int AW = $clog2(ALARM_TICKS + 1);
    localparam int HW = $clog2(CLR_TICKS + 1);
    localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_TICKS);
    localparam logic [HW-1:0] CLR_LAST   = HW'(CLR_TICKS - 1);

    typedef enum logic [1:0] {
        MODE_12H       = 2'd0,
        MODE_24H       = 2'd1,
        MODE_TIMER     = 2'd2,
        MODE_STOPWATCH = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        HOLD_IDLE  = 2'd0,
        HOLD_COUNT = 2'd1,
        HOLD_DONE  = 2'd2
    } hold_t;

    logic          armed_q;
    logic          prev_select_q;
    logic          prev_toggle_q;
    logic          prev_add_one_q;
    logic          prev_add_ten_q;

    mode_t         mode_q, mode_d;
    logic          tmr_run_q, tmr_run_d;
    logic          sw_run_q, sw_run_d;
    logic          sw_clear_q, sw_clear_d;
    logic          add_one_q, add_one_d;
    logic          add_ten_q, add_ten_d;
    logic          alarm_q, alarm_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    hold_t         hold_q, hold_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic select_press;
    logic toggle_press;
    logic toggle_release;
    logic add_one_press;
    logic add_ten_press;
    logic any_press;
    logic ack;
    logic mode_step;
    logic expire;
    logic timer_toggle;
    logic add_enable;

    // armed_q masks the first clk after reset so a button held through reset is not a press
    assign select_press   = armed_q & btn_select  & ~prev_select_q;
    assign toggle_press   = armed_q & btn_toggle  & ~prev_toggle_q;
    assign toggle_release = armed_q & ~btn_toggle & prev_toggle_q;
    assign add_one_press  = armed_q & btn_add_one & ~prev_add_one_q;
    assign add_ten_press  = armed_q & btn_add_ten & ~prev_add_ten_q;
    assign any_press      = select_press | toggle_press | add_one_press | add_ten_press;

    assign ack          = alarm_q & any_press;
    assign mode_step    = select_press & ~alarm_q;
    assign expire       = tmr_run_q & timer_zero & ~ack;
    assign timer_toggle = (mode_q == MODE_TIMER) & toggle_press & ~alarm_q & ~mode_step
                        & ~expire & ~(~tmr_run_q & timer_zero);
    assign add_enable   = (mode_q == MODE_TIMER) & ~tmr_run_q & ~alarm_q & field_valid & ~mode_step;

    always_comb begin
        tmr_field = 2'd0;
        if (hr_sw) begin
            tmr_field = 2'd3;
        end else if (min_sw) begin
            tmr_field = 2'd2;
        end else if (sec_sw) begin
            tmr_field = 2'd1;
        end
    end

    assign field_valid = ms_sw | sec_sw | min_sw | hr_sw;

    always_comb begin
        mode_d = mode_q;
        if (mode_step) begin
            mode_d = mode_t'(mode_q + 2'd1);
        end
    end

    always_comb begin
        tmr_run_d   = tmr_run_q;
        alarm_d     = alarm_q;
        alarm_cnt_d = alarm_cnt_q;
        if (ack) begin
            alarm_d     = 1'b0;
            alarm_cnt_d = '0;
        end else begin
            if (alarm_q && khz_tick) begin
                if (alarm_cnt_q <= AW'(1)) begin
                    alarm_d     = 1'b0;
                    alarm_cnt_d = '0;
                end else begin
                    alarm_cnt_d = alarm_cnt_q - AW'(1);
                end
            end
            if (expire) begin
                tmr_run_d   = 1'b0;
                alarm_d     = 1'b1;
                alarm_cnt_d = ALARM_LOAD;
            end else if (timer_toggle) begin
                tmr_run_d = ~tmr_run_q;
            end
        end
    end

    always_comb begin
        add_one_d = 1'b0;
        add_ten_d = 1'b0;
        if (add_enable) begin
            if (add_ten_press) begin
                add_ten_d = 1'b1;
            end else if (add_one_press) begin
                add_one_d = 1'b1;
            end
        end
    end

    // Hold tracking lives only in stopwatch mode; any mode change drops it, so a later release is ignored
    always_comb begin
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        sw_run_d   = sw_run_q;
        sw_clear_d = 1'b0;
        if (mode_step) begin
            hold_d     = HOLD_IDLE;
            hold_cnt_d = '0;
        end else if (mode_q == MODE_STOPWATCH) begin
            if (toggle_press && !alarm_q) begin
                hold_d     = HOLD_COUNT;
                hold_cnt_d = '0;
            end else if (toggle_release && hold_q != HOLD_IDLE) begin
                if (hold_q == HOLD_COUNT) begin
                    sw_run_d = ~sw_run_q;
                end
                hold_d     = HOLD_IDLE;
                hold_cnt_d = '0;
            end else if (hold_q == HOLD_COUNT && btn_toggle && khz_tick) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                if (hold_cnt_q == CLR_LAST) begin
                    sw_clear_d = 1'b1;
                    sw_run_d   = 1'b0;
                    hold_d     = HOLD_DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            armed_q        <= 1'b0;
            prev_select_q  <= 1'b0;
            prev_toggle_q  <= 1'b0;
            prev_add_one_q <= 1'b0;
            prev_add_ten_q <= 1'b0;
            mode_q         <= MODE_12H;
            tmr_run_q      <= 1'b0;
            sw_run_q       <= 1'b0;
            sw_clear_q     <= 1'b0;
            add_one_q      <= 1'b0;
            add_ten_q      <= 1'b0;
            alarm_q        <= 1'b0;
            alarm_cnt_q    <= '0;
            hold_q         <= HOLD_IDLE;
            hold_cnt_q     <= '0;
        end else begin
            armed_q        <= 1'b1;
            prev_select_q  <= btn_select;
            prev_toggle_q  <= btn_toggle;
            prev_add_one_q <= btn_add_one;
            prev_add_ten_q <= btn_add_ten;
            mode_q         <= mode_d;
            tmr_run_q      <= tmr_run_d;
            sw_run_q       <= sw_run_d;
            sw_clear_q     <= sw_clear_d;
            add_one_q      <= add_one_d;
            add_ten_q      <= add_ten_d;
            alarm_q        <= alarm_d;
            alarm_cnt_q    <= alarm_cnt_d;
            hold_q         <= hold_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign select      = mode_q;
    assign tmr_run     = tmr_run_q;
    assign sw_run      = sw_run_q;
    assign sw_clear    = sw_clear_q;
    assign tmr_add_one = add_one_q;
    assign tmr_add_ten = add_ten_q;
    assign alarm       = alarm_q;

endmodule

// File: tb/tb_mode_controller.sv
// Table-driven bench for mode_controller with a scoreboard queue of expected outputs.
// Stimulus word: {reset, sel, tog, one, ten, hr, min, sec, ms, timer_zero, khz_tick}.
module tb_mode_controller;

    localparam int ALARM_TICKS = 5;
    localparam int CLR_TICKS   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       khz_tick;
    logic       btn_select, btn_toggle, btn_add_one, btn_add_ten;
    logic       ms_sw, sec_sw, min_sw, hr_sw;
    logic       timer_zero;
    logic [1:0] select;
    logic       tmr_run, sw_run, sw_clear, tmr_add_one, tmr_add_ten;
    logic [1:0] tmr_field;
    logic       field_valid;
    logic       alarm;

    always #5 clk = ~clk;

    mode_controller #(
        .ALARM_TICKS(ALARM_TICKS),
        .CLR_TICKS  (CLR_TICKS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .khz_tick   (khz_tick),
        .btn_select (btn_select),
        .btn_toggle (btn_toggle),
        .btn_add_one(btn_add_one),
        .btn_add_ten(btn_add_ten),
        .ms_sw      (ms_sw),
        .sec_sw     (sec_sw),
        .min_sw     (min_sw),
        .hr_sw      (hr_sw),
        .timer_zero (timer_zero),
        .select     (select),
        .tmr_run    (tmr_run),
        .sw_run     (sw_run),
        .sw_clear   (sw_clear),
        .tmr_add_one(tmr_add_one),
        .tmr_add_ten(tmr_add_ten),
        .tmr_field  (tmr_field),
        .field_valid(field_valid),
        .alarm      (alarm)
    );

    typedef struct packed {
        logic [1:0] select;
        logic       tmr_run;
        logic       sw_run;
        logic       sw_clear;
        logic       add_one;
        logic       add_ten;
        logic [1:0] field;
        logic       field_valid;
        logic       alarm;
    } out_t;

    // Expected word: {select[1:0], tmr_run, sw_run, sw_clear, add_one, add_ten, alarm}
    typedef struct {
        string       name;
        logic [10:0] stim;
        logic [7:0]  expect_bits;
    } vec_t;

    typedef struct {
        string name;
        out_t  want;
    } sb_t;

    vec_t vectors[$];
    sb_t  scoreboard[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [10:0] S_IDLE    = 11'b0_0000_0000_00;
    localparam logic [10:0] S_SEL     = 11'b0_1000_0000_00;
    localparam logic [10:0] S_TOG     = 11'b0_0100_0000_00;
    localparam logic [10:0] S_TOGTICK = 11'b0_0100_0000_01;
    localparam logic [10:0] S_TICK    = 11'b0_0000_0000_01;
    localparam logic [10:0] S_TZ      = 11'b0_0000_0000_10;

    function automatic logic [1:0] field_model(input logic [3:0] sw);
        if (sw[3]) return 2'd3;
        if (sw[2]) return 2'd2;
        if (sw[1]) return 2'd1;
        return 2'd0;
    endfunction

    function automatic vec_t mk(input string name, input logic [10:0] stim, input logic [7:0] e);
        vec_t v;
        v.name        = name;
        v.stim        = stim;
        v.expect_bits = e;
        return v;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("sel=%0d tmr_run=%b sw_run=%b sw_clear=%b add_one=%b add_ten=%b field=%0d valid=%b alarm=%b",
                         o.select, o.tmr_run, o.sw_run, o.sw_clear, o.add_one, o.add_ten,
                         o.field, o.field_valid, o.alarm);
    endfunction

    task automatic applyStimulus(input vec_t v);
        sb_t item;
        reset       = v.stim[10];
        btn_select  = v.stim[9];
        btn_toggle  = v.stim[8];
        btn_add_one = v.stim[7];
        btn_add_ten = v.stim[6];
        hr_sw       = v.stim[5];
        min_sw      = v.stim[4];
        sec_sw      = v.stim[3];
        ms_sw       = v.stim[2];
        timer_zero  = v.stim[1];
        khz_tick    = v.stim[0];
        item.name             = v.name;
        item.want.select      = v.expect_bits[7:6];
        item.want.tmr_run     = v.expect_bits[5];
        item.want.sw_run      = v.expect_bits[4];
        item.want.sw_clear    = v.expect_bits[3];
        item.want.add_one     = v.expect_bits[2];
        item.want.add_ten     = v.expect_bits[1];
        item.want.alarm       = v.expect_bits[0];
        item.want.field       = field_model(v.stim[5:2]);
        item.want.field_valid = |v.stim[5:2];
        scoreboard.push_back(item);
    endtask

    task automatic checkOutput();
        sb_t  item;
        out_t got;
        checks++;
        if (scoreboard.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_empty: got output with no expected entry");
            return;
        end
        item = scoreboard.pop_front();
        got  = {select, tmr_run, sw_run, sw_clear, tmr_add_one, tmr_add_ten, tmr_field, field_valid, alarm};
        if (got !== item.want) begin
            errors++;
            $display("[TB] FAIL %s: got %s, want %s", item.name, fmt(got), fmt(item.want));
        end
    endtask

    task automatic step(input string name, input logic [10:0] stim, input logic [7:0] e);
        applyStimulus(mk(name, stim, e));
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors.push_back(mk("reset",             11'b1_0000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("reset_sel_held",    11'b1_1000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("held_thru_reset",   11'b0_1000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("sel_to_1",          11'b0_1000_0000_00, 8'b01_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b01_00_000_0));
        vectors.push_back(mk("sel_to_2",          11'b0_1000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("sel_to_3",          11'b0_1000_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("sel_wrap_0",        11'b0_1000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b00_00_000_0));
        vectors.push_back(mk("sel_to_1b",         11'b0_1000_0000_00, 8'b01_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b01_00_000_0));
        vectors.push_back(mk("sel_to_timer",      11'b0_1000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("rel",               11'b0_0000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("add_one_hr_sec",    11'b0_0010_1010_00, 8'b10_00_010_0));
        vectors.push_back(mk("add_one_rel",       11'b0_0000_1010_00, 8'b10_00_000_0));
        vectors.push_back(mk("add_both",          11'b0_0011_1010_00, 8'b10_00_001_0));
        vectors.push_back(mk("add_both_rel",      11'b0_0000_1010_00, 8'b10_00_000_0));
        vectors.push_back(mk("tmr_start",         11'b0_0100_1010_00, 8'b10_10_000_0));
        vectors.push_back(mk("tmr_start_rel",     11'b0_0000_1010_00, 8'b10_10_000_0));
        vectors.push_back(mk("add_ten_running",   11'b0_0001_1010_00, 8'b10_10_000_0));
        vectors.push_back(mk("add_ten_rel",       11'b0_0000_1010_00, 8'b10_10_000_0));
        vectors.push_back(mk("tmr_stop",          11'b0_0100_1010_00, 8'b10_00_000_0));
        vectors.push_back(mk("tmr_stop_rel",      11'b0_0000_1010_00, 8'b10_00_000_0));
        vectors.push_back(mk("add_no_field",      11'b0_0010_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("add_no_field_rel",  11'b0_0000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("zero_no_start",     11'b0_0100_0000_10, 8'b10_00_000_0));
        vectors.push_back(mk("zero_rel",          11'b0_0000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("tmr_start2",        11'b0_0100_0000_00, 8'b10_10_000_0));
        vectors.push_back(mk("tmr_start2_rel",    11'b0_0000_0000_00, 8'b10_10_000_0));
        vectors.push_back(mk("expiry",            11'b0_0000_0000_10, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_tick1",       11'b0_0000_0000_01, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_idle",        11'b0_0000_0000_00, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_tick2",       11'b0_0000_0000_01, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_tick3",       11'b0_0000_0000_01, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_tick4",       11'b0_0000_0000_01, 8'b10_00_000_1));
        vectors.push_back(mk("alarm_tick5_end",   11'b0_0000_0000_01, 8'b10_00_000_0));
        vectors.push_back(mk("alarm_after",       11'b0_0000_0000_01, 8'b10_00_000_0));
        vectors.push_back(mk("tmr_start3",        11'b0_0100_0000_00, 8'b10_10_000_0));
        vectors.push_back(mk("tmr_start3_rel",    11'b0_0000_0000_00, 8'b10_10_000_0));
        vectors.push_back(mk("expiry_with_tog",   11'b0_0100_0000_10, 8'b10_00_000_1));
        vectors.push_back(mk("expiry_tog_rel",    11'b0_0000_0000_00, 8'b10_00_000_1));
        vectors.push_back(mk("alarm2_tick1",      11'b0_0000_0000_01, 8'b10_00_000_1));
        vectors.push_back(mk("ack_by_select",     11'b0_1000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("ack_rel",           11'b0_0000_0000_00, 8'b10_00_000_0));
        vectors.push_back(mk("ack_tick",          11'b0_0000_0000_01, 8'b10_00_000_0));
        vectors.push_back(mk("sel_and_add",       11'b0_1010_0001_00, 8'b11_00_000_0));
        vectors.push_back(mk("sel_and_add_rel",   11'b0_0000_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("sw_short_press",    11'b0_0100_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("sw_short_t1",       11'b0_0100_0000_01, 8'b11_00_000_0));
        vectors.push_back(mk("sw_short_t2",       11'b0_0100_0000_01, 8'b11_00_000_0));
        vectors.push_back(mk("sw_short_rel",      11'b0_0000_0000_00, 8'b11_01_000_0));
        vectors.push_back(mk("sw_long_press",     11'b0_0100_0000_00, 8'b11_01_000_0));
        vectors.push_back(mk("sw_long_t1",        11'b0_0100_0000_01, 8'b11_01_000_0));
        vectors.push_back(mk("sw_long_t2",        11'b0_0100_0000_01, 8'b11_01_000_0));
        vectors.push_back(mk("sw_long_t3",        11'b0_0100_0000_01, 8'b11_01_000_0));
        vectors.push_back(mk("sw_long_t4_clear",  11'b0_0100_0000_01, 8'b11_00_100_0));
        vectors.push_back(mk("sw_long_t5",        11'b0_0100_0000_01, 8'b11_00_000_0));
        vectors.push_back(mk("sw_long_t6",        11'b0_0100_0000_01, 8'b11_00_000_0));
        vectors.push_back(mk("sw_long_rel",       11'b0_0000_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("sw_start_press",    11'b0_0100_0000_00, 8'b11_00_000_0));
        vectors.push_back(mk("sw_start_rel",      11'b0_0000_0000_00, 8'b11_01_000_0));
        vectors.push_back(mk("abandon_press",     11'b0_0100_0000_00, 8'b11_01_000_0));
        vectors.push_back(mk("abandon_t1",        11'b0_0100_0000_01, 8'b11_01_000_0));
        vectors.push_back(mk("abandon_sel",       11'b0_1100_0000_01, 8'b00_01_000_0));
        vectors.push_back(mk("abandon_t3",        11'b0_0100_0000_01, 8'b00_01_000_0));
        vectors.push_back(mk("abandon_t4",        11'b0_0100_0000_01, 8'b00_01_000_0));
        vectors.push_back(mk("abandon_rel",       11'b0_0000_0000_00, 8'b00_01_000_0));
        vectors.push_back(mk("clock_mode_tog",    11'b0_0100_0000_00, 8'b00_01_000_0));
        vectors.push_back(mk("clock_mode_rel",    11'b0_0000_0000_00, 8'b00_01_000_0));

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i]);
            @(negedge clk);
            checkOutput();
        end

        // Reset in the middle of a stopwatch hold, one tick before the clear would fire
        for (int i = 1; i <= 3; i++) begin
            logic [1:0] s;
            s = i[1:0];
            step("rh_nav_sel", S_SEL,  {s, 2'b01, 3'b000, 1'b0});
            step("rh_nav_rel", S_IDLE, {s, 2'b01, 3'b000, 1'b0});
        end
        step("rh_press", S_TOG, 8'b11_01_000_0);
        for (int i = 0; i < 3; i++) begin
            step("rh_hold_tick", S_TOGTICK, 8'b11_01_000_0);
        end
        step("rh_reset", 11'b1_0100_0000_01, 8'b00_00_000_0);
        for (int i = 0; i < 3; i++) begin
            step("rh_after_reset", S_TOGTICK, 8'b00_00_000_0);
        end
        step("rh_rel", S_IDLE, 8'b00_00_000_0);

        // Reset in the middle of an alarm
        for (int i = 1; i <= 2; i++) begin
            logic [1:0] s;
            s = i[1:0];
            step("ra_nav_sel", S_SEL,  {s, 2'b00, 3'b000, 1'b0});
            step("ra_nav_rel", S_IDLE, {s, 2'b00, 3'b000, 1'b0});
        end
        step("ra_tmr_start", S_TOG,  8'b10_10_000_0);
        step("ra_tmr_rel",   S_IDLE, 8'b10_10_000_0);
        step("ra_expiry",    S_TZ,   8'b10_00_000_1);
        step("ra_tick",      S_TICK, 8'b10_00_000_1);
        step("ra_reset",     11'b1_0000_0000_01, 8'b00_00_000_0);
        for (int i = 0; i < 3; i++) begin
            step("ra_after_reset", S_TICK, 8'b00_00_000_0);
        end

        if (scoreboard.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, want 0", scoreboard.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
